// File: rtl/trafficlight_monitor.sv
// Receiving-end checker for hwy/road light codes: decodes them to one-hot lamp drives and
// flags illegal codes, conflicts, bad phase order and short yellow/all-red dwell times.
module trafficlight_monitor #(
   parameter int YEL_MIN    = 3,
   parameter int ALLRED_MIN = 2,
   parameter int DW         = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic [1:0]       hwy,
   input  logic [1:0]       road,
   input  logic             err_clr,
   output logic [2:0]       hwy_lamp,
   output logic [2:0]       road_lamp,
   output logic             err_illegal,
   output logic             err_conflict,
   output logic             err_sequence,
   output logic             err_timing,
   output logic             err_any,
   output logic [2:0]       first_err,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {PH_HG, PH_HY, PH_AR, PH_RG, PH_RY, PH_BAD} phase_e;

   localparam logic [1:0]    C_RED = 2'b00, C_GRN = 2'b01, C_YEL = 2'b10, C_ILL = 2'b11;
   localparam logic [DW-1:0] DWELL_MAX = {DW{1'b1}};
   localparam logic [DW-1:0] YEL_MIN_W = DW'(YEL_MIN);
   localparam logic [DW-1:0] AR_MIN_W  = DW'(ALLRED_MIN);

   function automatic logic [2:0] lamp_of(input logic [1:0] code);
      case (code)
         C_RED:   lamp_of = 3'b100;
         C_GRN:   lamp_of = 3'b001;
         C_YEL:   lamp_of = 3'b010;
         default: lamp_of = 3'b000;
      endcase
   endfunction

   function automatic phase_e succ_of(input phase_e p);
      case (p)
         PH_HG:   succ_of = PH_HY;
         PH_HY:   succ_of = PH_AR;
         PH_AR:   succ_of = PH_RG;
         PH_RG:   succ_of = PH_RY;
         PH_RY:   succ_of = PH_HG;
         default: succ_of = PH_BAD;
      endcase
   endfunction

   phase_e           phase_q, phase_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [2:0]       hwy_lamp_q, road_lamp_q;
   logic [3:0]       flags_q, flags_d;
   logic             err_any_q;
   logic [2:0]       first_q, first_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic   samp_ill, samp_conf, changed, legal_exit, seq_v, tim_v;
   phase_e new_phase;
   logic [2:0] new_code;

   // Classify the sampled pair; code 11 wins over conflict.
   always_comb begin
      samp_ill  = (hwy == C_ILL) || (road == C_ILL);
      samp_conf = !samp_ill && (hwy != C_RED) && (road != C_RED);
      new_phase = PH_BAD;
      if (!samp_ill && !samp_conf) begin
         case ({hwy, road})
            {C_GRN, C_RED}: new_phase = PH_HG;
            {C_YEL, C_RED}: new_phase = PH_HY;
            {C_RED, C_RED}: new_phase = PH_AR;
            {C_RED, C_GRN}: new_phase = PH_RG;
            {C_RED, C_YEL}: new_phase = PH_RY;
            default:        new_phase = PH_BAD;
         endcase
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         phase_q     <= PH_HG;
         dwell_q     <= DW'(1);
         hwy_lamp_q  <= 3'b001;
         road_lamp_q <= 3'b100;
         flags_q     <= 4'b0000;
         err_any_q   <= 1'b0;
         first_q     <= 3'b000;
         count_q     <= '0;
      end else begin
         phase_q     <= phase_d;
         dwell_q     <= dwell_d;
         hwy_lamp_q  <= lamp_of(hwy);
         road_lamp_q <= lamp_of(road);
         flags_q     <= flags_d;
         err_any_q   <= |flags_d;
         first_q     <= first_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      changed = (new_phase != phase_q);
      phase_d = new_phase;
      if (changed)                 dwell_d = DW'(1);
      else if (dwell_q == DWELL_MAX) dwell_d = dwell_q;
      else                         dwell_d = dwell_q + DW'(1);
   end

   // Entering BAD is reported by the illegal/conflict flags only; leaving BAD is a recovery.
   always_comb begin
      legal_exit = changed && (phase_q != PH_BAD) && (new_phase == succ_of(phase_q));
      seq_v      = changed && (phase_q != PH_BAD) && (new_phase != PH_BAD) && !legal_exit;
      tim_v      = legal_exit &&
                   ((((phase_q == PH_HY) || (phase_q == PH_RY)) && (dwell_q < YEL_MIN_W)) ||
                    ((phase_q == PH_AR) && (dwell_q < AR_MIN_W)));
      if (samp_ill)       new_code = 3'b001;
      else if (samp_conf) new_code = 3'b010;
      else if (seq_v)     new_code = 3'b011;
      else if (tim_v)     new_code = 3'b100;
      else                new_code = 3'b000;
      flags_d = (flags_q & {4{~err_clr}}) | {tim_v, seq_v, samp_conf, samp_ill};
      first_d = (err_clr || (first_q == 3'b000)) ? new_code : first_q;
      count_d = (legal_exit && (phase_q == PH_RY)) ? count_q + CNT_W'(1) : count_q;
   end

   assign hwy_lamp     = hwy_lamp_q;
   assign road_lamp    = road_lamp_q;
   assign err_illegal  = flags_q[0];
   assign err_conflict = flags_q[1];
   assign err_sequence = flags_q[2];
   assign err_timing   = flags_q[3];
   assign err_any      = err_any_q;
   assign first_err    = first_q;
   assign cycle_count  = count_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Bench for trafficlight_monitor: directed scenarios followed by randomized phase sequences,
// all checked against a phase-ring reference model.
module tb_trafficlight_monitor;

   localparam int YEL_MIN = 3, ALLRED_MIN = 2, DW = 4, CNT_W = 8;

   logic             clock = 1'b0;
   logic             clear_n = 1'b0;
   logic [1:0]       hwy = 2'b01, road = 2'b00;
   logic             err_clr = 1'b0;
   logic [2:0]       hwy_lamp, road_lamp, first_err;
   logic             err_illegal, err_conflict, err_sequence, err_timing, err_any;
   logic [CNT_W-1:0] cycle_count;

   int checks = 0;
   int errors = 0;

   trafficlight_monitor #(.YEL_MIN(YEL_MIN), .ALLRED_MIN(ALLRED_MIN), .DW(DW), .CNT_W(CNT_W)) dut (
      .clock(clock), .clear_n(clear_n), .hwy(hwy), .road(road), .err_clr(err_clr),
      .hwy_lamp(hwy_lamp), .road_lamp(road_lamp), .err_illegal(err_illegal),
      .err_conflict(err_conflict), .err_sequence(err_sequence), .err_timing(err_timing),
      .err_any(err_any), .first_err(first_err), .cycle_count(cycle_count));

   always #5 clock = ~clock;

   // Phase ring HG,HY,AR,RG,RY as index 0..4; -1 is the BAD pseudo-phase.
   int ph_h[5] = '{1, 2, 0, 0, 0};
   int ph_r[5] = '{0, 0, 0, 1, 2};
   int ph_min[5];

   int m_ph, m_run, m_count, m_first;
   bit m_ill, m_conf, m_seq, m_tim;
   int m_hl, m_rl;

   function automatic int lamp_exp(input int code);
      return (code == 0) ? 4 : (code == 1) ? 1 : (code == 2) ? 2 : 0;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_run = 1; m_count = 0; m_first = 0;
      m_ill = 0; m_conf = 0; m_seq = 0; m_tim = 0;
      m_hl = 1; m_rl = 4;
   endtask

   task automatic model_update(input int h, input int r, input bit clr);
      bit ill, conf, seq, tim;
      int np, code;
      ill  = (h == 3) || (r == 3);
      conf = !ill && (h != 0) && (r != 0);
      np = -1;
      if (!ill && !conf)
         for (int i = 0; i < 5; i++) if (ph_h[i] == h && ph_r[i] == r) np = i;
      seq = 0; tim = 0;
      if (np != m_ph && m_ph != -1 && np != -1) begin
         if (np == (m_ph + 1) % 5) begin
            tim = (m_run < ph_min[m_ph]);
            if (m_ph == 4) m_count = (m_count + 1) % (1 << CNT_W);
         end else seq = 1;
      end
      m_run = (np == m_ph) ? m_run + 1 : 1;
      m_ph  = np;
      code = ill ? 1 : conf ? 2 : seq ? 3 : tim ? 4 : 0;
      m_ill  = (m_ill  && !clr) || ill;
      m_conf = (m_conf && !clr) || conf;
      m_seq  = (m_seq  && !clr) || seq;
      m_tim  = (m_tim  && !clr) || tim;
      if (clr || m_first == 0) m_first = code;
      m_hl = lamp_exp(h);
      m_rl = lamp_exp(r);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("lamps", {26'd0, hwy_lamp, road_lamp}, 32'(m_hl * 8 + m_rl));
      chk("flags", {27'd0, err_any, err_timing, err_sequence, err_conflict, err_illegal},
          {27'd0, (m_ill | m_conf | m_seq | m_tim), m_tim, m_seq, m_conf, m_ill});
      chk("first_err", {29'd0, first_err}, 32'(m_first));
      chk("cycle_count", {24'd0, cycle_count}, 32'(m_count));
   endtask

   task automatic step(input int h, input int r, input bit clr);
      hwy = 2'(h); road = 2'(r); err_clr = clr;
      @(posedge clock);
      model_update(h, r, clr);
      #1;
      compare_all();
      err_clr = 1'b0;
   endtask

   task automatic run_phase(input int p, input int n);
      for (int i = 0; i < n; i++) step(ph_h[p], ph_r[p], 1'b0);
   endtask

   // Reset is asserted asynchronously away from the clock edge and checked straight away.
   task automatic do_reset();
      clear_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   task automatic full_cycle(input int hy_len);
      run_phase(0, 5); run_phase(1, hy_len); run_phase(2, 2); run_phase(3, 4); run_phase(4, 3);
   endtask

   initial begin
      int d, n, sel;
      ph_min = '{0, YEL_MIN, ALLRED_MIN, 0, YEL_MIN};
      model_reset();
      @(negedge clock);
      do_reset();

      // 1: clean cycle, count reaches 1
      full_cycle(3);
      run_phase(0, 2);
      // 2: short yellow
      do_reset();
      full_cycle(2);
      run_phase(0, 1);
      // 3: skip HY, then clear
      do_reset();
      run_phase(0, 3);
      run_phase(2, 2);
      step(ph_h[2], ph_r[2], 1'b1);
      // 4: illegal code then recovery to HG
      do_reset();
      run_phase(0, 2);
      step(3, 0, 1'b0);
      run_phase(0, 3);
      // 5: conflict together with err_clr
      step(1, 1, 1'b1);
      run_phase(0, 2);
      // 6: reset mid-RG after a completed cycle
      do_reset();
      full_cycle(3);
      run_phase(0, 5); run_phase(1, 3); run_phase(2, 2); run_phase(3, 2);
      do_reset();
      run_phase(0, 4);
      run_phase(1, 3);

      // Randomized legal/illegal phase traffic with sporadic clears and resets.
      d = 1;
      for (int it = 0; it < 300; it++) begin
         sel = $urandom_range(0, 24);
         if (sel == 0) step(3, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
         else if (sel == 1) step($urandom_range(1, 2), $urandom_range(1, 2), 1'b0);
         else if (sel == 2) begin
            d = $urandom_range(0, 4);
            run_phase(d, $urandom_range(1, 4));
         end else if (sel == 3) begin
            do_reset();
            d = 0;
         end else begin
            d = (d + 1) % 5;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) step(ph_h[d], ph_r[d], $urandom_range(0, 15) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
